// File: rtl/usb_bit_unstuff.sv
// ---------------------------------------------------------------------------
// usb_bit_unstuff
//
// Receive-side USB bit unstuffer. Sits between the NRZI decoder and the
// packet receiver / CRC checker.
//
// The first SYNC_BITS accepted bits of a packet (SYNC + PID) are passed
// through untouched and are not counted as part of any ones run. After that,
// every 0 that follows a run of six 1s is a stuffed bit and is deleted. If a
// 1 shows up where the stuffed 0 belongs, the packet is corrupt: a stuff
// error is flagged and the rest of the packet is discarded until eop.
//
// All outputs are registered, so a bit accepted in cycle k appears on the
// output in cycle k+1.
//
// Ports
//   clk            clock
//   rst_n          asynchronous, active-low reset
//   start_i        one-cycle packet start, only looked at while idle
//   s_in_i         decoded serial bit, qualified by bit_valid_i
//   bit_valid_i    s_in_i carries a bit this cycle
//   eop_i          one-cycle end-of-packet from the line logic
//   s_out_o        unstuffed data bit (holds its value when not valid)
//   s_out_valid_o  s_out_o carries a bit this cycle
//   stuff_err_o    one-cycle pulse: a 1 arrived where a stuffed 0 was due
//   done_o         one-cycle pulse: packet reception finished
//   busy_o         high whenever the block is not idle
// ---------------------------------------------------------------------------
module usb_bit_unstuff #(
  parameter int SYNC_BITS = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start_i,
  input  logic s_in_i,
  input  logic bit_valid_i,
  input  logic eop_i,
  output logic s_out_o,
  output logic s_out_valid_o,
  output logic stuff_err_o,
  output logic done_o,
  output logic busy_o
);

  localparam int SPW = $clog2(SYNC_BITS + 1);
  localparam logic [SPW-1:0] SP_LAST = SPW'(SYNC_BITS - 1);
  localparam logic [SPW-1:0] SP_ONE  = SPW'(1);
  localparam logic [2:0]     RUN_MAX = 3'd6;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SYNC = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;
  localparam logic [1:0] S_ERR  = 2'd3;

  logic [1:0]     state_q, state_d;
  logic [SPW-1:0] sp_cnt_q, sp_cnt_d;
  logic [2:0]     ones_q, ones_d;
  logic           s_out_q, s_out_d;
  logic           vld_q, vld_d;
  logic           err_q, err_d;
  logic           done_q, done_d;
  logic           busy_q, busy_d;

  always_comb begin
    state_d  = state_q;
    sp_cnt_d = sp_cnt_q;
    ones_d   = ones_q;
    s_out_d  = s_out_q;   // output bit holds between valid strobes
    vld_d    = 1'b0;
    err_d    = 1'b0;
    done_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        // bit_valid and eop are meaningless between packets
        if (start_i) begin
          sp_cnt_d = '0;
          ones_d   = '0;
          state_d  = S_SYNC;
        end
      end

      S_SYNC: begin
        // sync/PID bits go straight through and never feed the ones run
        if (bit_valid_i) begin
          s_out_d  = s_in_i;
          vld_d    = 1'b1;
          sp_cnt_d = sp_cnt_q + SP_ONE;
          if (sp_cnt_q == SP_LAST) state_d = S_DATA;
        end
      end

      S_DATA: begin
        if (bit_valid_i) begin
          if (ones_q == RUN_MAX) begin
            // this bit must be the stuffed 0
            if (s_in_i) begin
              err_d   = 1'b1;
              state_d = S_ERR;
            end else begin
              ones_d = '0;
            end
          end else begin
            s_out_d = s_in_i;
            vld_d   = 1'b1;
            ones_d  = s_in_i ? ones_q + 3'd1 : 3'd0;
          end
        end
      end

      S_ERR: begin
        // drop everything until the line reports end of packet
      end

      default: state_d = S_IDLE;
    endcase

    // eop closes any active packet; a bit arriving with it was handled above
    if (state_q != S_IDLE && eop_i) begin
      done_d  = 1'b1;
      state_d = S_IDLE;
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      sp_cnt_q <= '0;
      ones_q   <= '0;
      s_out_q  <= 1'b0;
      vld_q    <= 1'b0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sp_cnt_q <= sp_cnt_d;
      ones_q   <= ones_d;
      s_out_q  <= s_out_d;
      vld_q    <= vld_d;
      err_q    <= err_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  assign s_out_o       = s_out_q;
  assign s_out_valid_o = vld_q;
  assign stuff_err_o   = err_q;
  assign done_o        = done_q;
  assign busy_o        = busy_q;

endmodule

// File: tb/tb_usb_bit_unstuff.sv
// ---------------------------------------------------------------------------
// tb_usb_bit_unstuff
//
// Bench for usb_bit_unstuff: a per-cycle vector table for the sync phase and
// back-to-back start, hand-written packets for the stuffing corner cases and
// reset abort, and random packets scored against a packet-level model.
// ---------------------------------------------------------------------------
module tb_usb_bit_unstuff;
  localparam int SB = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start_i = 1'b0, s_in_i = 1'b0, bit_valid_i = 1'b0, eop_i = 1'b0;
  logic s_out_o, s_out_valid_o, stuff_err_o, done_o, busy_o;

  usb_bit_unstuff #(.SYNC_BITS(SB)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .s_in_i(s_in_i),
    .bit_valid_i(bit_valid_i), .eop_i(eop_i), .s_out_o(s_out_o),
    .s_out_valid_o(s_out_valid_o), .stuff_err_o(stuff_err_o),
    .done_o(done_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  int errs, dones, exp_err;
  bit outq[$], pkt[$], expq[$];

  typedef struct {
    logic       st, bv, b, e;
    logic [4:0] exp;   // {valid, s_out, stuff_err, done, busy}
  } vec_t;
  vec_t tbl[19];

  task automatic chk(input string nm, input int idx, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %0d expected %0d", nm, idx, act, exp);
    end
  endtask

  // one clock: drive inputs, sample the registered response just after the edge
  task automatic step(input logic st, input logic bv, input logic b, input logic e);
    start_i = st; bit_valid_i = bv; s_in_i = b; eop_i = e;
    @(posedge clk); #1;
    if (s_out_valid_o) outq.push_back(s_out_o);
    if (stuff_err_o) errs++;
    if (done_o) dones++;
    start_i = 1'b0; bit_valid_i = 1'b0; eop_i = 1'b0;
  endtask

  task automatic clear_sb();
    outq.delete(); errs = 0; dones = 0;
  endtask

  task automatic add_bits(input int n, input bit v);
    for (int i = 0; i < n; i++) pkt.push_back(v);
  endtask

  // Packet-level reference: sync bits verbatim, then drop the 0 after six 1s;
  // a 1 in that slot is an error and nothing further is produced.
  function automatic void model();
    int run;
    expq.delete(); exp_err = 0; run = 0;
    for (int i = 0; i < pkt.size(); i++) begin
      if (i < SB) expq.push_back(pkt[i]);
      else if (run == 6) begin
        if (pkt[i]) begin exp_err = 1; break; end
        run = 0;
      end else begin
        expq.push_back(pkt[i]);
        run = pkt[i] ? run + 1 : 0;
      end
    end
  endfunction

  // gap: fixed idle cycles before each bit; rnd: random 0..3 instead
  task automatic send_pkt(input int gap, input bit rnd, input bit eop_last);
    clear_sb();
    step(1, 0, 0, 0);
    for (int i = 0; i < pkt.size(); i++) begin
      int g;
      g = rnd ? (($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0) : gap;
      repeat (g) step(0, 0, 0, 0);
      step(0, 1, pkt[i], eop_last && (i == pkt.size() - 1));
    end
    if (!eop_last || pkt.size() == 0) step(0, 0, 0, 1);
    step(0, 0, 0, 0);
  endtask

  task automatic check_pkt(input string nm, input int idx);
    int mis;
    model();
    chk({nm, ".count"}, idx, outq.size(), expq.size());
    mis = 0;
    for (int i = 0; i < expq.size() && i < outq.size(); i++)
      if (outq[i] != expq[i]) mis++;
    chk({nm, ".bits_wrong"}, idx, mis, 0);
    chk({nm, ".stuff_err"}, idx, errs, exp_err);
    chk({nm, ".done"}, idx, dones, 1);
    chk({nm, ".busy_after"}, idx, int'(busy_o), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    bit [15:0] pat;
    pat = 16'b0000000100000001;

    // ---- reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset", 0, int'({s_out_valid_o, s_out_o, stuff_err_o, done_o, busy_o}), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // ---- table: start (bit ignored), 16 sync bits with eop on last,
    //      back-to-back start, then eop with no bits (short packet)
    tbl[0] = '{1, 1, 1, 0, 5'b00001};
    for (int j = 0; j < 16; j++) begin
      logic b;
      b = pat[15 - j];
      tbl[1 + j] = '{0, 1, b, (j == 15), {1'b1, b, 1'b0, (j == 15), (j != 15)}};
    end
    tbl[17] = '{1, 0, 0, 0, 5'b01001};
    tbl[18] = '{0, 0, 0, 1, 5'b01010};
    clear_sb();
    for (int i = 0; i < 19; i++) begin
      step(tbl[i].st, tbl[i].bv, tbl[i].b, tbl[i].e);
      chk("vec", i, int'({s_out_valid_o, s_out_o, stuff_err_o, done_o, busy_o}), int'(tbl[i].exp));
    end
    chk("vec.stuff_err_total", 0, errs, 0);

    // ---- stuffed zero removed: payload 1111110 1 0
    pkt.delete(); add_bits(SB, 0); add_bits(6, 1); add_bits(1, 0);
    add_bits(1, 1); add_bits(1, 0);
    send_pkt(0, 0, 1);
    check_pkt("stuffdrop", 0);
    chk("stuffdrop.len", 0, outq.size(), 24);

    // ---- stuff error: payload 1111111 101, timing checked per cycle
    clear_sb();
    step(1, 0, 0, 0);
    for (int i = 0; i < SB; i++) step(0, 1, 0, 0);
    for (int i = 0; i < 6; i++) step(0, 1, 1, 0);
    step(0, 1, 1, 0);
    chk("stufferr.pulse", 0, int'(stuff_err_o), 1);
    chk("stufferr.no_valid", 0, int'(s_out_valid_o), 0);
    step(0, 1, 1, 0); step(0, 1, 0, 0);
    chk("stufferr.one_pulse", 0, errs, 1);
    step(0, 1, 1, 0);
    step(0, 0, 0, 1);
    chk("stufferr.done", 0, int'(done_o), 1);
    chk("stufferr.busy", 0, int'(busy_o), 0);
    chk("stufferr.count", 0, outq.size(), SB + 6);

    // ---- sync ones are not counted
    pkt.delete(); add_bits(SB, 1); add_bits(1, 0); add_bits(1, 1);
    send_pkt(0, 0, 0);
    check_pkt("syncones", 0);
    chk("syncones.len", 0, outq.size(), 18);

    // ---- gapped input: run holds across idle cycles
    pkt.delete(); add_bits(SB, 0); add_bits(6, 1); add_bits(1, 0); add_bits(1, 1);
    send_pkt(3, 0, 1);
    check_pkt("gapped", 0);
    chk("gapped.len", 0, outq.size(), SB + 7);

    // ---- reset mid-DATA after four payload 1s
    clear_sb();
    step(1, 0, 0, 0);
    for (int i = 0; i < SB; i++) step(0, 1, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 1, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset", 0, int'({s_out_valid_o, s_out_o, stuff_err_o, done_o, busy_o}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 0, 0, 0);
    chk("midreset.no_done", 0, dones, 0);
    pkt.delete(); add_bits(SB, 0); add_bits(6, 1); add_bits(1, 0);
    send_pkt(0, 0, 1);
    check_pkt("afterreset", 0);
    chk("afterreset.len", 0, outq.size(), SB + 6);

    // ---- random packets, ones-heavy to exercise stuffing and errors
    for (int p = 0; p < 60; p++) begin
      int len;
      len = $urandom_range(0, 70);
      pkt.delete();
      for (int i = 0; i < len; i++) pkt.push_back($urandom_range(0, 9) < 8);
      send_pkt(0, 1, $urandom_range(0, 1));
      check_pkt("rand", p);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
